cla_nibble_seq: RTL



---
 rtl/cla_pkg.sv | 17 +
 rtl/bit4_cla.sv | 28 ++
 rtl/cla_nibble_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder datapath.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-nibble build still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/bit4_cla.sv
// 4-bit carry-lookahead adder slice; all carries are computed in parallel from generate/propagate terms.
module bit4_cla
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] ain,
    input  logic [NIB_W-1:0] bin,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] c;

    assign g = ain & bin;
    assign p = ain ^ bin;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/cla_nibble_seq.sv
// Multi-cycle W-bit adder/subtractor that time-shares one bit4_cla, one nibble per clock, LSB first.
module cla_nibble_seq
    import cla_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    part_q, part_d;
    logic [W-1:0]    sum_q;
    logic            cout_q, ovf_q;
    logic            accept, finish;
    logic [W-1:0]    a_sh, b_sh;
    logic [NIB_W-1:0] cla_sum;
    logic            cla_cout;

    // Nibble select: shift by idx*4 so the active slice sits in the low bits.
    assign a_sh = a_q >> {idx_q, 2'b00};
    assign b_sh = b_q >> {idx_q, 2'b00};

    bit4_cla u_cla (
        .ain  (a_sh[NIB_W-1:0]),
        .bin  (b_sh[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_comb begin
        part_d = part_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) part_d[i*NIB_W +: NIB_W] = cla_sum;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                    idx_d   = '0;
                    carry_d = sub ? 1'b1 : cin;
                end
            end
            ST_RUN: begin
                carry_d = cla_cout;
                if (idx_q == IDX_LAST) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else if (idx_q < IDX_LAST) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                carry_d = 1'b0;
            end
        endcase
    end

    // Operand and partial-sum storage carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
        end
        if (state_q == ST_RUN) part_q <= part_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            if (finish) begin
                sum_q  <= part_d;
                cout_q <= cla_cout;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (part_d[W-1] != a_q[W-1]);
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
